// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: hex glyph table, blank pattern, polarity helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package seg7_pkg;

  // Glyphs are {g,f,e,d,c,b,a}, active-high, indexed by hex digit.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] seg_pol(input logic [6:0] s, input logic active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high gfedcba glyph lookup.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  assign glyph = SEG_HEX[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-digit 7-segment driver with shadowed load, LZ blanking and blink.
// Latency: seg/an follow the scan index by 1 cycle; loads become visible at the next frame boundary.
// Backpressure: none; load is always accepted, later loads overwrite the shadow (upd_pending flags it).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_blank,
  output logic                  upd_pending,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [FW-1:0]     FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]       scan_cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       frm_cnt;
  logic                blink_on;

  logic [4*DIGITS-1:0] shd_val;
  logic [DIGITS-1:0]   shd_en;
  logic [DIGITS-1:0]   shd_mask;
  logic [4*DIGITS-1:0] act_val;
  logic [DIGITS-1:0]   act_en;
  logic [DIGITS-1:0]   act_mask;

  logic                scan_wrap;
  logic                frame_end;
  logic [DIGITS-1:0]   lz_mask;
  logic                nz_above;
  logic [3:0]          cur_nib;
  logic [6:0]          cur_glyph;
  logic                lit;
  logic [6:0]          seg_nxt;
  logic [DIGITS-1:0]   an_nxt;

  assign scan_wrap = (scan_cnt == CNT_LAST);
  assign frame_end = scan_wrap && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blink phase flips every BLINK_FRAMES complete frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt  <= '0;
      blink_on <= 1'b1;
    end else if (frame_end) begin
      if (frm_cnt == FRM_LAST) begin
        frm_cnt  <= '0;
        blink_on <= ~blink_on;
      end else begin
        frm_cnt  <= frm_cnt + 1'b1;
      end
    end
  end

  // Shadow captures on load; active copies the shadow only at a frame boundary so a frame never tears.
  // A load on the boundary cycle lands in the shadow while active takes the previous shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd_val     <= '0;
      shd_en      <= '0;
      shd_mask    <= '0;
      act_val     <= '0;
      act_en      <= '0;
      act_mask    <= '0;
      upd_pending <= 1'b0;
    end else begin
      if (load) begin
        shd_val  <= value;
        shd_en   <= dig_en;
        shd_mask <= blink_mask;
      end
      if (frame_end && upd_pending) begin
        act_val  <= shd_val;
        act_en   <= shd_en;
        act_mask <= shd_mask;
      end
      if (load) begin
        upd_pending <= 1'b1;
      end else if (frame_end) begin
        upd_pending <= 1'b0;
      end
    end
  end

  // Walk from the most significant digit down; a digit is a leading zero while no enabled
  // non-zero nibble has been seen at or above it. Digit 0 always shows.
  always_comb begin
    lz_mask  = '0;
    nz_above = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (act_en[i] && (act_val[4*i +: 4] != 4'h0)) begin
        nz_above = 1'b1;
      end
      lz_mask[i] = lz_blank && !nz_above && (i != 0);
    end
  end

  assign cur_nib = act_val[{idx, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nib   (cur_nib),
    .glyph (cur_glyph)
  );

  assign lit = act_en[idx] && !(!blink_on && act_mask[idx]) && !lz_mask[idx];

  always_comb begin
    seg_nxt = SEG_OFF;
    an_nxt  = '0;
    if (lit) begin
      seg_nxt = cur_glyph;
      an_nxt  = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= seg_pol(SEG_OFF, ACTIVE_LOW);
      an  <= AN_OFF;
    end else begin
      seg <= seg_pol(seg_nxt, ACTIVE_LOW);
      an  <= ACTIVE_LOW ? ~an_nxt : an_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slots, 2-frame blink, active-low).
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int P  = ND * SD;

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct { int e; logic [15:0] v; logic [3:0] en; logic [3:0] m; } ld_t;
  typedef struct { logic [6:0] seg; logic [3:0] an; logic pend; } exp_t;

  logic        clk, rst, load, lz_blank, upd_pending;
  logic [15:0] value;
  logic [3:0]  dig_en, blink_mask, an;
  logic [6:0]  seg;

  ld_t  ld_q[$];
  exp_t exp_q[$];
  int   k;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_driver #(
    .DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dig_en(dig_en),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .upd_pending(upd_pending),
    .seg(seg), .an(an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", nm, k, act, expv);
    end
  endtask

  // Reference: k counts clock edges since reset release. The display after edge kk shows the
  // slot/frame of time kk-1; frame f shows the last load taken strictly before that frame began.
  function automatic exp_t model(int kk);
    exp_t x;
    ld_t  a;
    int   j, slot, f;
    bit   on, nzhi, lzb, lit;
    logic [3:0] nib;
    x.seg = 7'h7F; x.an = 4'hF; x.pend = 1'b0;
    if (kk == 0) return x;
    j    = kk - 1;
    slot = (j / SD) % ND;
    f    = j / P;
    a    = '{0, 16'h0, 4'h0, 4'h0};
    foreach (ld_q[i]) if (ld_q[i].e < f * P) a = ld_q[i];
    if (ld_q.size() > 0 && ld_q[ld_q.size()-1].e >= (kk / P) * P) x.pend = 1'b1;
    on   = ((f / BF) % 2) == 0;
    nzhi = 1'b0;
    for (int i = ND - 1; i >= slot; i--)
      if (a.en[i] && (((a.v >> (4 * i)) & 16'hF) != 0)) nzhi = 1'b1;
    lzb = lz_blank && (slot != 0) && !nzhi;
    lit = a.en[slot] && !(!on && a.m[slot]) && !lzb;
    if (lit) begin
      nib   = 4'(a.v >> (4 * slot));
      x.seg = ~HEX[nib];
      x.an  = ~(4'b0001 << slot);
    end
    return x;
  endfunction

  task automatic cyc(input logic ld, input logic [15:0] v, input logic [3:0] e, input logic [3:0] m);
    load = ld; value = v; dig_en = e; blink_mask = m;
    @(posedge clk);
    if (rst) begin
      k = 0;
      ld_q.delete();
    end else begin
      k++;
      if (ld) ld_q.push_back('{k, v, e, m});
    end
    exp_q.push_back(model(k));
    #1;
    load = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic run(input int n);
    repeat (n) idle();
  endtask

  function automatic logic [15:0] rnd_val();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < ND; i++)
      if ($urandom_range(0, 1) == 1) v = v | (16'($urandom_range(0, 15)) << (4 * i));
    return v;
  endfunction

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("seg", {25'b0, seg}, {25'b0, x.seg});
        chk("an", {28'b0, an}, {28'b0, x.an});
        chk("upd_pending", {31'b0, upd_pending}, {31'b0, x.pend});
      end
    end
  end

  initial begin : stim
    rst = 1'b0; load = 1'b0; value = '0; dig_en = '0; blink_mask = '0; lz_blank = 1'b0; k = 0;
    #2 rst = 1'b1;
    #1;
    chk("reset_seg", {25'b0, seg}, 32'h7F);
    chk("reset_an", {28'b0, an}, 32'hF);
    chk("reset_upd", {31'b0, upd_pending}, 32'h0);
    repeat (3) idle();
    rst = 1'b0;

    cyc(1'b1, 16'h12AF, 4'hF, 4'h0);
    run(3 * P);

    lz_blank = 1'b1;
    cyc(1'b1, 16'h0030, 4'hF, 4'h0);
    run(2 * P);
    lz_blank = 1'b0;
    run(2 * P);

    while (((k / SD) % ND) != 1) idle();
    cyc(1'b1, 16'h4567, 4'hF, 4'h0);
    run(2 * P);

    while (((k + 1) % P) != 0) idle();
    cyc(1'b1, 16'h89AB, 4'hF, 4'h0);
    run(2 * P);

    cyc(1'b1, 16'hCDEF, 4'hF, 4'h0);
    cyc(1'b1, 16'h3210, 4'hF, 4'h0);
    run(2 * P);

    cyc(1'b1, 16'h1111, 4'hF, 4'b0001);
    run(8 * P);

    cyc(1'b1, 16'h8888, 4'b0101, 4'h0);
    run(2 * P);

    repeat (400) begin
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 15) == 0)
        cyc(1'b1, rnd_val(), 4'($urandom), 4'($urandom));
      else
        idle();
    end

    // Async reset while digit 2 is lit with a load still pending.
    lz_blank = 1'b0;
    while ((k % P) != 0) idle();
    cyc(1'b1, 16'hFEDC, 4'hF, 4'h0);
    while ((((k - 1) / SD) % ND) != 2) idle();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_seg", {25'b0, seg}, 32'h7F);
    chk("async_an", {28'b0, an}, 32'hF);
    chk("async_upd", {31'b0, upd_pending}, 32'h0);
    repeat (2) idle();
    rst = 1'b0;
    run(2 * P);
    cyc(1'b1, 16'h0001, 4'hF, 4'h0);
    run(2 * P);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
